fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side controller for the async FIFO memory. It shares the single memory write port between NUM_REQ write requesters using round-robin arbitration and owns the write pointer in binary and Gray form. It computes full (and optionally almost-full) against the read pointer that has already been synchronized into the write clock domain. It drives the memory's write enable, address and data directly, and exports the Gray write pointer to the read-side synchronizer.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one FIFO word
- ADDR_WIDTH, 6, memory address width; depth = 2**ADDR_WIDTH
- NUM_REQ, 4, number of write requesters (≥2)
- AFULL_MARGIN, 4, free-slot threshold for wafull; used only with the macro

Ports:
- clk_wr  in  1  write-domain clock; the block's only clock
- wrst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot accept; the word transfers when req_valid[i] & req_ready[i]
- rptr_gray_sync  in  ADDR_WIDTH+1  read pointer in Gray code, already synchronized to clk_wr
- wr_en  out  1  memory write enable
- waddr  out  ADDR_WIDTH  memory write address
- wdata  out  DATA_WIDTH  memory write data
- wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain
- wfull  out  1  registered full flag
- wafull  out  1  registered almost-full flag
- grant_id  out  $clog2(NUM_REQ)  index of the current winner; valid when wr_en=1

## Operation
- State:
  - wbin[ADDR_WIDTH:0]
  - wptr_gray[ADDR_WIDTH:0]
  - wfull
  - wafull
  - rr_ptr, the highest-priority index
- Arbitration is combinational. The winner is the first asserted req_valid found scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- req_ready[winner] = ~wfull. All other req_ready bits are 0. With no valid requests, req_ready = 0.
- Write-port outputs:
  - wr_en = (|req_valid) & ~wfull
  - waddr = wbin[ADDR_WIDTH-1:0]
  - wdata = req_data slice of the winner
  - grant_id = winner
- On each clk_wr edge with wr_en=1:
  - wbin ← wbin+1, wrapping modulo 2**(ADDR_WIDTH+1)
  - wptr_gray ← gray(wbin+1)
  - rr_ptr ← (winner+1) mod NUM_REQ
- wfull is registered. It is 1 when gray(wbin_next) equals rptr_gray_sync with its two MSBs inverted, where wbin_next = wbin + wr_en.
- If wr_en=0, wbin, wptr_gray and rr_ptr hold, but wfull is still re-evaluated every cycle. wfull clears one cycle after rptr_gray_sync advances.
- Requesters hold valid and data until accepted.
  - A newly asserted request may win ahead of a waiting one if it has higher current priority.
  - Data is never lost or duplicated.
  - Starvation is impossible: after a write, the winner has the lowest priority.
- Reset (wrst_n=0, any time) forces, asynchronously:
  - wbin=0, wptr_gray=0, wfull=0, wafull=0, rr_ptr=0
  - wr_en=0 and req_ready=0 for the duration of reset
- A handshake in progress when reset asserts is dropped. The requester re-presents it after reset.

## Timing
- The write occurs at the same clk_wr edge as the handshake. Latency from req_valid to memory write is 0 cycles when the requester wins and wfull=0.
- wptr_gray, wfull and wafull update at that same edge, so they are visible the cycle after the write.
- Full boundary: with rptr_gray_sync=0 and a continuous stream, the 64th write (ADDR_WIDTH=6) sets wfull at its edge. No 65th write occurs.
- wr_en=1 is never issued while wfull=1, even if rptr_gray_sync moves in the same cycle.
- Wrap-around: waddr goes 63→0 and wbin goes 127→0. Full detection stays correct across the wrap.

## Configuration
- FIFO_WR_ARB_AFULL_EN defined:
  - rptr_gray_sync is converted Gray→binary to rbin.
  - wafull is registered as 1 when (wbin_next − rbin) mod 2**(ADDR_WIDTH+1) ≥ 2**ADDR_WIDTH − AFULL_MARGIN.
  - wafull is informational only and does not gate writes.
- Not defined: wafull is tied to 0, and no Gray→binary logic is synthesized.

## Test plan
- Reset: assert wrst_n=0 mid-stream -> wr_en=0, req_ready=0, wptr_gray=0, wfull=0 immediately; first write after release goes to waddr=0.
- Round-robin fairness: all 4 req_valid held high for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3; waddr 0..7.
- Fill to full: a single requester streams with rptr_gray_sync=0 -> 64 writes at waddr 0..63; wfull=1 after the 64th edge; req_ready=0 thereafter.
- Drain release: from full, rptr_gray_sync set to gray(1) -> wfull=0 next cycle; the next write goes to waddr=0 with wptr_gray=gray(65).
- Wrap: keep rptr_gray_sync trailing by 10 through 200 writes -> waddr wraps 63→0 and wbin 127→0; wfull never asserts.
- Almost-full (macro defined, AFULL_MARGIN=4): rptr_gray_sync=0 -> wafull=1 after the 60th write, 0 before it; macro undefined -> wafull stays 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Purpose : write-side controller of the async FIFO; round-robin shares one memory write port among
//           NUM_REQ requesters and owns the binary/Gray write pointer plus the full flags.
// Latency : 0 cycles request-to-write (the handshake edge is the write edge); pointer/flags visible next cycle.
// Backpr. : req_ready is one-hot to the winner and is dropped entirely while wfull=1 or during reset.
//
// Ports: clk_wr/wrst_n (only clock, async active-low reset); req_valid/req_data/req_ready (requester side,
//        requester i on req_data[i*DATA_WIDTH +: DATA_WIDTH]); rptr_gray_sync (read pointer already in
//        this domain); wr_en/waddr/wdata (memory write port); wptr_gray (to read-side synchronizer);
//        wfull/wafull (registered flags); grant_id (winner index, meaningful when wr_en=1).
// Option : define FIFO_WR_ARB_AFULL_EN to build the almost-full flag; otherwise wafull is constant 0.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int NUM_REQ      = 4,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                          clk_wr,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [ADDR_WIDTH:0]           rptr_gray_sync,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         waddr,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [ADDR_WIDTH:0]           wptr_gray,
    output logic                          wfull,
    output logic                          wafull,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("fifo_wr_arbiter: NUM_REQ must be at least 2");
    end
    if (AFULL_MARGIN < 0 || AFULL_MARGIN > (2 ** ADDR_WIDTH)) begin : g_bad_margin
        $error("fifo_wr_arbiter: AFULL_MARGIN must lie within 0..depth");
    end

    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] wbin_next;
    logic [ADDR_WIDTH:0] wgray_next;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      rr_next;
    logic [IDW-1:0]      winner;
    logic                any_req;
    logic                full_next;

    // Scan offsets from the far end back towards rr_ptr so the closest valid
    // requester (highest priority) is the last one written and therefore wins.
    always_comb begin
        int           idx;
        logic [IDW-1:0] cand;
        idx    = 0;
        cand   = '0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDW'(idx);
            if (req_valid[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == IDW'(k)) begin
                wdata = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign any_req = |req_valid;
    // wrst_n gates the port combinationally so nothing is accepted while reset is held.
    assign wr_en   = any_req & ~wfull & wrst_n;

    always_comb begin
        req_ready = '0;
        if (wr_en) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign waddr    = wbin[ADDR_WIDTH-1:0];
    assign grant_id = winner;

    assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wr_en};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    // Full: write pointer one lap ahead of read pointer; in Gray code that is the
    // read pointer with its two MSBs inverted.
    assign full_next  = (wgray_next == {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                                        rptr_gray_sync[ADDR_WIDTH-2:0]});
    assign rr_next    = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    // Pointer and flag are loaded every cycle: with wr_en=0 the next values equal
    // the current pointer, while wfull still follows the moving read pointer.
    always_ff @(posedge clk_wr or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr_gray <= '0;
            wfull     <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            wfull     <= full_next;
            if (wr_en) begin
                rr_ptr <= rr_next;
            end
        end
    end

`ifdef FIFO_WR_ARB_AFULL_EN
    localparam logic [ADDR_WIDTH:0] AFULL_THRESH = (ADDR_WIDTH+1)'((2 ** ADDR_WIDTH) - AFULL_MARGIN);

    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] wused;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            rbin[i] = ^(rptr_gray_sync >> i);
        end
    end

    assign wused = wbin_next - rbin;

    always_ff @(posedge clk_wr or negedge wrst_n) begin
        if (!wrst_n) begin
            wafull <= 1'b0;
        end else begin
            wafull <= (wused >= AFULL_THRESH);
        end
    end
`else
    assign wafull = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int NR    = 4;
    localparam int AM    = 4;
    localparam int DEPTH = 64;
    localparam int PMOD  = 128;

    logic               clk_wr = 1'b0;
    logic               wrst_n;
    logic [NR-1:0]      req_valid;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic [AW:0]        rptr_gray_sync;
    logic               wr_en;
    logic [AW-1:0]      waddr;
    logic [DW-1:0]      wdata;
    logic [AW:0]        wptr_gray;
    logic               wfull;
    logic               wafull;
    logic [1:0]         grant_id;

    fifo_wr_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .NUM_REQ     (NR),
        .AFULL_MARGIN(AM)
    ) dut (
        .clk_wr        (clk_wr),
        .wrst_n        (wrst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rptr_gray_sync(rptr_gray_sync),
        .wr_en         (wr_en),
        .waddr         (waddr),
        .wdata         (wdata),
        .wptr_gray     (wptr_gray),
        .wfull         (wfull),
        .wafull        (wafull),
        .grant_id      (grant_id)
    );

    always #5 clk_wr = ~clk_wr;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: counts of words written / read, the requester that wrote
    // last, and each requester's pending word.
    int             writes;
    int             reads;
    int             last_win;
    bit             exp_full;
    bit             exp_afull;
    bit             pending [NR];
    logic [DW-1:0]  pdata   [NR];

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = pending[i];
            req_data[i*DW +: DW]   = pdata[i];
        end
        rptr_gray_sync = gray(reads % PMOD);
    endtask

    task automatic present(input logic [NR-1:0] allow, input int pct);
        for (int i = 0; i < NR; i++) begin
            if (allow[i] && !pending[i] && ($urandom_range(99) < pct)) begin
                pending[i] = 1'b1;
                pdata[i]   = DW'($urandom);
            end
        end
        drive_inputs();
    endtask

    task automatic model_reset();
        writes    = 0;
        reads     = 0;
        last_win  = NR - 1;
        exp_full  = 1'b0;
        exp_afull = 1'b0;
    endtask

    // One clock cycle, entered and left at the negedge. Outputs are checked
    // mid-low-phase, the model advances at the posedge.
    task automatic step(input string tag);
        int            win;
        int            bd;
        int            d;
        int            fill;
        bit            ew;
        logic [NR-1:0] erdy;
        logic [AW-1:0] eaddr;
        logic [AW:0]   egray;
        logic [1:0]    egid;
        drive_inputs();
        #1;
        win = -1;
        bd  = NR + 1;
        // Highest priority goes to the requester just after the last winner.
        for (int i = 0; i < NR; i++) begin
            if (pending[i]) begin
                d = (i - last_win - 1 + 2 * NR) % NR;
                if (d < bd) begin
                    bd  = d;
                    win = i;
                end
            end
        end
        ew    = (win >= 0) && !exp_full;
        erdy  = '0;
        if (ew) erdy[win] = 1'b1;
        eaddr = AW'(writes % DEPTH);
        egray = gray(writes % PMOD);
        vectors++;
        if (wr_en !== ew) begin
            miscompares++;
            $display("FAIL %s wr_en got %b exp %b (t=%0t)", tag, wr_en, ew, $time);
        end
        vectors++;
        if (req_ready !== erdy) begin
            miscompares++;
            $display("FAIL %s req_ready got %b exp %b (t=%0t)", tag, req_ready, erdy, $time);
        end
        vectors++;
        if (wfull !== exp_full) begin
            miscompares++;
            $display("FAIL %s wfull got %b exp %b (t=%0t)", tag, wfull, exp_full, $time);
        end
        vectors++;
        if (wafull !== exp_afull) begin
            miscompares++;
            $display("FAIL %s wafull got %b exp %b (t=%0t)", tag, wafull, exp_afull, $time);
        end
        vectors++;
        if (wptr_gray !== egray) begin
            miscompares++;
            $display("FAIL %s wptr_gray got %h exp %h (t=%0t)", tag, wptr_gray, egray, $time);
        end
        if (ew) begin
            egid = 2'(win);
            vectors++;
            if (grant_id !== egid) begin
                miscompares++;
                $display("FAIL %s grant_id got %0d exp %0d (t=%0t)", tag, grant_id, egid, $time);
            end
            vectors++;
            if (waddr !== eaddr) begin
                miscompares++;
                $display("FAIL %s waddr got %0d exp %0d (t=%0t)", tag, waddr, eaddr, $time);
            end
            vectors++;
            if (wdata !== pdata[win]) begin
                miscompares++;
                $display("FAIL %s wdata got %h exp %h (t=%0t)", tag, wdata, pdata[win], $time);
            end
        end
        @(posedge clk_wr);
        if (ew) begin
            writes++;
            last_win     = win;
            pending[win] = 1'b0;
        end
        fill     = ((writes - reads) % PMOD + PMOD) % PMOD;
        exp_full = (fill == DEPTH);
`ifdef FIFO_WR_ARB_AFULL_EN
        exp_afull = (fill >= DEPTH - AM);
`else
        exp_afull = 1'b0;
`endif
        @(negedge clk_wr);
    endtask

    task automatic apply_reset();
        wrst_n = 1'b0;
        model_reset();
        drive_inputs();
        @(posedge clk_wr);
        @(negedge clk_wr);
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < NR; i++) begin
            pending[i] = 1'b1;
            pdata[i]   = DW'($urandom);
        end
        wrst_n = 1'b0;
        drive_inputs();
        #2;
        vectors++;
        if (wr_en !== 1'b0 || req_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_hold wr_en=%b req_ready=%b exp 0/0", wr_en, req_ready);
        end
        vectors++;
        if (wptr_gray !== '0 || wfull !== 1'b0 || wafull !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state wptr_gray=%h wfull=%b wafull=%b exp 0/0/0", wptr_gray, wfull, wafull);
        end
        @(negedge clk_wr);
        wrst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            present(4'hF, 70);
            step("pre_reset");
        end
        present(4'hF, 100);
        #2;
        wrst_n = 1'b0;
        model_reset();
        drive_inputs();
        #1;
        vectors++;
        if (wr_en !== 1'b0 || req_ready !== '0) begin
            miscompares++;
            $display("FAIL midreset_port wr_en=%b req_ready=%b exp 0/0", wr_en, req_ready);
        end
        vectors++;
        if (wptr_gray !== '0 || wfull !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state wptr_gray=%h wfull=%b exp 0/0", wptr_gray, wfull);
        end
        @(posedge clk_wr);
        @(negedge clk_wr);
        wrst_n = 1'b1;
        #1;
        vectors++;
        if (wr_en !== 1'b1 || waddr !== '0) begin
            miscompares++;
            $display("FAIL first_after_reset wr_en=%b waddr=%0d exp 1/0", wr_en, waddr);
        end
        step("post_reset");
    endtask

    task automatic test_round_robin();
        logic [1:0] eg;
        logic [AW-1:0] ea;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            present(4'hF, 100);
            #1;
            eg = 2'(k % NR);
            ea = AW'(k);
            vectors++;
            if (grant_id !== eg || waddr !== ea) begin
                miscompares++;
                $display("FAIL rr_seq[%0d] grant_id=%0d waddr=%0d exp %0d/%0d", k, grant_id, waddr, eg, ea);
            end
            step("round_robin");
        end
    endtask

    task automatic test_fill_drain();
        logic [AW:0] eg65;
        apply_reset();
        for (int k = 0; k < DEPTH; k++) begin
            present(4'b0100, 100);
            step("fill");
        end
        vectors++;
        if (wfull !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_full wfull got %b exp 1", wfull);
        end
        for (int k = 0; k < 3; k++) begin
            present(4'hF, 100);
            step("held_full");
        end
        reads = 1;
        step("drain_edge");
        vectors++;
        if (wfull !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_release wfull got %b exp 0", wfull);
        end
        step("after_drain");
        eg65 = gray(65);
        vectors++;
        if (wptr_gray !== eg65) begin
            miscompares++;
            $display("FAIL drain_gray wptr_gray got %h exp %h", wptr_gray, eg65);
        end
    endtask

    task automatic test_wrap();
        int budget;
        apply_reset();
        budget = 0;
        while (writes < 200 && budget < 2000) begin
            reads = (writes > 10) ? writes - 10 : 0;
            present(4'hF, 60);
            step("wrap");
            budget++;
        end
        vectors++;
        if (writes < 200) begin
            miscompares++;
            $display("FAIL wrap_budget writes got %0d exp 200", writes);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            if (reads < writes && $urandom_range(99) < 35) reads++;
            present(4'($urandom), 50);
            step("random");
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            pending[i] = 1'b0;
            pdata[i]   = '0;
        end
        wrst_n         = 1'b0;
        req_valid      = '0;
        req_data       = '0;
        rptr_gray_sync = '0;
        test_reset();
        test_round_robin();
        test_fill_drain();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
